// File: rtl/fpq_pkg.sv
// Shared definitions for the FPQ tone transmitter.
// Holds the band encoding, the FSM state type, the default half-period
// base/step values and the common counter width. No ports.
package fpq_pkg;

  localparam int CNT_W = 12;

  localparam int H_BASE_DEF = 600;
  localparam int H_STEP_DEF = 20;
  localparam int L_BASE_DEF = 3000;
  localparam int L_STEP_DEF = 100;

  typedef enum logic [1:0] {
    BAND_NONE = 2'b00,
    BAND_H    = 2'b01,
    BAND_L    = 2'b10,
    BAND_ILL  = 2'b11
  } band_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_TONE = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  function automatic logic band_legal(input logic [1:0] band);
    return (band == BAND_H) || (band == BAND_L);
  endfunction

endpackage

// File: rtl/fpq_tone_tx_if.sv
// Request/status bundle of the FPQ tone transmitter.
//   start, active_i, channel_i, abort : requester -> transmitter
//   tone_out, busy, active_o, channel_o, done, err : transmitter -> requester
// master = requester side, slave = transmitter side.
interface fpq_tone_tx_if;
  logic       start;
  logic [1:0] active_i;
  logic [3:0] channel_i;
  logic       abort;
  logic       tone_out;
  logic       busy;
  logic [1:0] active_o;
  logic [3:0] channel_o;
  logic       done;
  logic       err;

  modport master (
    output start, active_i, channel_i, abort,
    input  tone_out, busy, active_o, channel_o, done, err
  );

  modport slave (
    input  start, active_i, channel_i, abort,
    output tone_out, busy, active_o, channel_o, done, err
  );
endinterface

// File: rtl/fpq_half_period_lut.sv
// Band/channel to half-period lookup (purely combinational).
//   band        in  2       band code (NONE/H/L/illegal)
//   channel     in  4       channel index 0..15
//   half_period out CNT_W   half-period in clocks; 0 for NONE/illegal
// Arithmetic wraps at CNT_W bits, unsigned.
module fpq_half_period_lut
  import fpq_pkg::*;
#(
  parameter int H_BASE = H_BASE_DEF,
  parameter int H_STEP = H_STEP_DEF,
  parameter int L_BASE = L_BASE_DEF,
  parameter int L_STEP = L_STEP_DEF
) (
  input  logic [1:0]       band,
  input  logic [3:0]       channel,
  output logic [CNT_W-1:0] half_period
);

  logic [CNT_W-1:0] ch_ext;
  assign ch_ext = CNT_W'(channel);

  always_comb begin
    half_period = '0;
    case (band)
      BAND_H:  half_period = CNT_W'(H_BASE) - CNT_W'(H_STEP) * ch_ext;
      BAND_L:  half_period = CNT_W'(L_BASE) - CNT_W'(L_STEP) * ch_ext;
      default: half_period = '0;
    endcase
  end

endmodule

// File: rtl/fpq_tone_tx.sv
// FPQ tone burst transmitter.
//   clk_12MHz in  sole clock, rising edge
//   rst       in  asynchronous active-high reset
//   bus       slave modport of fpq_tone_tx_if (start/abort/band/channel in;
//             tone_out/busy/active_o/channel_o/done/err out)
// A legal start emits N_CYC square-wave periods (high half first) at the
// band/channel half-period, then GAP_CLKS silent clocks, then pulses done.
//
// state   | meaning
// IDLE    | waiting for start; outputs cleared
// TONE    | emitting square wave, half-period counter running
// GAP     | silent guard interval before done
module fpq_tone_tx
  import fpq_pkg::*;
#(
  parameter int N_CYC    = 16,
  parameter int GAP_CLKS = 1200,
  parameter int H_BASE   = H_BASE_DEF,
  parameter int H_STEP   = H_STEP_DEF,
  parameter int L_BASE   = L_BASE_DEF,
  parameter int L_STEP   = L_STEP_DEF
) (
  input  logic        clk_12MHz,
  input  logic        rst,
  fpq_tone_tx_if.slave bus
);

  // Period counter holds completed periods 0..N_CYC-1; the last one goes
  // straight to GAP instead of being stored.
  localparam int PER_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;
  // Gap counter runs GAP_CLKS-1 down to 0.
  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             tone_q, tone_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       band_q, band_d;
  logic [3:0]       chan_q, chan_d;
  logic [CNT_W-1:0] hp_lut;
  logic             to_idle;

  fpq_half_period_lut #(
    .H_BASE (H_BASE),
    .H_STEP (H_STEP),
    .L_BASE (L_BASE),
    .L_STEP (L_STEP)
  ) u_lut (
    .band        (bus.active_i),
    .channel     (bus.channel_i),
    .half_period (hp_lut)
  );

  always_ff @(posedge clk_12MHz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hp_q    <= '0;
      per_q   <= '0;
      gap_q   <= '0;
      tone_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      band_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      per_q   <= per_d;
      gap_q   <= gap_d;
      tone_q  <= tone_d;
      done_q  <= done_d;
      err_q   <= err_d;
      band_q  <= band_d;
      chan_q  <= chan_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    per_d   = per_q;
    gap_d   = gap_q;
    tone_d  = tone_q;
    band_d  = band_q;
    chan_d  = chan_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    to_idle = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort in IDLE swallows a coincident start, including its err
        if (bus.start && !bus.abort) begin
          if (band_legal(bus.active_i)) begin
            state_d = ST_TONE;
            hp_d    = hp_lut;
            cnt_d   = hp_lut - CNT_W'(1);
            per_d   = '0;
            tone_d  = 1'b1;
            band_d  = bus.active_i;
            chan_d  = bus.channel_i;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_TONE: begin
        if (bus.abort) begin
          to_idle = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (tone_q) begin
          tone_d = 1'b0;
          cnt_d  = hp_q - CNT_W'(1);
        end else if (per_q == PER_W'(N_CYC - 1)) begin
          // low half of the final period expired: line stays low
          state_d = ST_GAP;
          gap_d   = GAP_W'(GAP_CLKS - 1);
          per_d   = '0;
          cnt_d   = '0;
        end else begin
          per_d  = per_q + PER_W'(1);
          tone_d = 1'b1;
          cnt_d  = hp_q - CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (bus.abort) begin
          to_idle = 1'b1;
        end else if (gap_q == '0) begin
          to_idle = 1'b1;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: to_idle = 1'b1;
    endcase

    if (to_idle) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      per_d   = '0;
      gap_d   = '0;
      tone_d  = 1'b0;
      band_d  = '0;
      chan_d  = '0;
    end
  end

  assign bus.tone_out  = tone_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.active_o  = band_q;
  assign bus.channel_o = chan_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_fpq_tone_tx.sv
// Randomized self-checking bench for fpq_tone_tx (N_CYC=2, GAP_CLKS=4,
// default half-period tables). Expected outputs per clock are derived from
// the burst timeline: high/low halves of HP clocks, then the guard gap,
// then a done pulse.
module tb_fpq_tone_tx;
  localparam int N = 2;
  localparam int G = 4;

  logic clk_12MHz = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_burst = 0;

  fpq_tone_tx_if bus ();

  fpq_tone_tx #(
    .N_CYC    (N),
    .GAP_CLKS (G)
  ) dut (
    .clk_12MHz (clk_12MHz),
    .rst       (rst),
    .bus       (bus.slave)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {tone_out, busy, done, err, active_o, channel_o}
  function automatic logic [9:0] obs_vec();
    return {bus.tone_out, bus.busy, bus.done, bus.err, bus.active_o, bus.channel_o};
  endfunction

  function automatic int ref_hp(input logic [1:0] b, input logic [3:0] c);
    int ci;
    ci = int'(c);
    return (b == 2'b01) ? (600 - 20 * ci) : (3000 - 100 * ci);
  endfunction

  // expected outputs k clocks after the edge that sampled start
  function automatic logic [9:0] ref_vec(input int k, input logic [1:0] b,
                                         input logic [3:0] c, input int ab);
    int hp;
    int t;
    logic hi;
    hp = ref_hp(b, c);
    t  = 2 * N * hp;
    if (ab != 0 && k > ab) return '0;
    if (k <= t) begin
      hi = (((k - 1) / hp) % 2) == 0;
      return {hi, 1'b1, 1'b0, 1'b0, b, c};
    end
    if (k <= t + G) return {1'b0, 1'b1, 1'b0, 1'b0, b, c};
    if (k == t + G + 1) return 10'b0010_000000;
    return '0;
  endfunction

  // Starts a burst at the current negedge and checks every following clock.
  // ab: abort driven during clock ab (0 = none). spur: random starts while busy.
  task automatic run_burst(input logic [1:0] b, input logic [3:0] c,
                           input int ab, input bit spur);
    int t;
    int last;
    t    = 2 * N * ref_hp(b, c);
    last = (ab != 0) ? ab + 3 : t + G + 2;
    n_burst++;
    bus.start     = 1'b1;
    bus.active_i  = b;
    bus.channel_i = c;
    bus.abort     = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk_12MHz);
      chk($sformatf("burst%0d k%0d", n_burst, k), 32'(obs_vec()), 32'(ref_vec(k, b, c, ab)));
      bus.start = 1'b0;
      bus.abort = (k == ab);
      if (spur && k <= t + G && (ab == 0 || k <= ab) &&
          (k == t + G || $urandom_range(0, 7) == 0)) begin
        bus.start     = 1'b1;
        bus.active_i  = 2'($urandom_range(0, 3));
        bus.channel_i = 4'($urandom_range(0, 15));
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    logic [1:0] rb;
    logic [3:0] rc;
    int         rab;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.active_i  = 2'b00;
    bus.channel_i = 4'd0;
    bus.abort     = 1'b0;
    repeat (3) @(negedge clk_12MHz);
    chk("reset", 32'(obs_vec()), 32'h0);
    rst = 1'b0;
    @(negedge clk_12MHz);
    chk("idle", 32'(obs_vec()), 32'h0);

    // H ch0: 600/600 twice, 4 gap clocks, done at clock 2405
    run_burst(2'b01, 4'd0, 0, 1'b0);
    // L ch15: half-period 1500, with starts arriving while busy
    run_burst(2'b10, 4'd15, 0, 1'b1);

    // illegal bands
    for (int i = 0; i < 2; i++) begin
      bus.start    = 1'b1;
      bus.active_i = (i == 0) ? 2'b11 : 2'b00;
      bus.channel_i = 4'd5;
      @(negedge clk_12MHz);
      chk("err_pulse", 32'(obs_vec()), 32'h040);
      bus.start = 1'b0;
      @(negedge clk_12MHz);
      chk("err_clear", 32'(obs_vec()), 32'h0);
    end

    // abort during clock 700 of H ch0
    run_burst(2'b01, 4'd0, 700, 1'b0);

    // abort coincident with start in IDLE
    bus.start     = 1'b1;
    bus.abort     = 1'b1;
    bus.active_i  = 2'b01;
    bus.channel_i = 4'd3;
    @(negedge clk_12MHz);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_idle", 32'(obs_vec()), 32'h0);
    repeat (3) @(negedge clk_12MHz);
    chk("abort_start_quiet", 32'(obs_vec()), 32'h0);

    // reset mid-TONE, then a full burst started on the release edge
    bus.start     = 1'b1;
    bus.active_i  = 2'b01;
    bus.channel_i = 4'd2;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk_12MHz);
      bus.start = 1'b0;
    end
    chk("pre_rst_tone", 32'(obs_vec()), 32'(ref_vec(300, 2'b01, 4'd2, 0)));
    rst = 1'b1;
    #1;
    chk("async_rst", 32'(obs_vec()), 32'h0);
    @(negedge clk_12MHz);
    chk("rst_hold", 32'(obs_vec()), 32'h0);
    rst = 1'b0;
    run_burst(2'b10, 4'd12, 0, 1'b0);

    // randomized bursts
    repeat (5) begin
      rb  = 2'($urandom_range(1, 2));
      rc  = (rb == 2'b01) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(8, 15));
      rab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * N * ref_hp(rb, rc) + G)) : 0;
      run_burst(rb, rc, rab, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
